// File: rtl/dpram_rr_arbiter_if.sv
// Client-side bus of the dual-port RAM round-robin arbiter: requests in, grants and read returns out.
// Requester i occupies bits [i*AW +: AW] of req_addr and [i*DW +: DW] of req_wdata/rdata.
interface dpram_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 4,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [N*DW-1:0] rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the A/B ports of an external RAM.
// Define RAM_ARB_HAZARD_EN to suppress the B grant when it collides with A on an address and either writes.
module dpram_rr_arbiter #(
  parameter int N  = 4,
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  dpram_rr_arbiter_if.slave bus,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  input  logic [DW-1:0] ram_douta,
  output logic          ram_web,
  output logic [AW-1:0] ram_addrb,
  output logic [DW-1:0] ram_dinb,
  input  logic [DW-1:0] ram_doutb
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic          a_found, b_found, b_gnt, hazard;
  logic [IW-1:0] a_idx, b_idx;
  logic          a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          own_a_vld, own_b_vld;
  logic [IW-1:0] own_a_idx, own_b_idx;
  logic [N*DW-1:0] rdata_q;
  logic [N*DW-1:0] rdata_v;
  logic [N-1:0]    rvalid_v;
  logic [N-1:0]    gnt_v;

  // Circular scan from ptr for A, then onward from A's winner for B.
  always_comb begin : scan
    logic [IW-1:0] ia;
    logic [IW-1:0] ib;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    a_found = 1'b0;
    a_idx   = '0;
    b_found = 1'b0;
    b_idx   = '0;
    ia      = '0;
    ib      = '0;
    for (int k = 0; k < N; k++) begin
      ia = IW'((int'(ptr) + k) % N);
      if (!a_found && bus.req[ia]) begin
        a_found = 1'b1;
        a_idx   = ia;
      end
    end
    for (int k = 1; k < N; k++) begin
      ib = IW'((int'(a_idx) + k) % N);
      if (a_found && !b_found && bus.req[ib]) begin
        b_found = 1'b1;
        b_idx   = ib;
      end
    end
  end

  assign a_we    = bus.req_we[a_idx];
  assign a_addr  = bus.req_addr[int'(a_idx)*AW +: AW];
  assign a_wdata = bus.req_wdata[int'(a_idx)*DW +: DW];
  assign b_we    = bus.req_we[b_idx];
  assign b_addr  = bus.req_addr[int'(b_idx)*AW +: AW];
  assign b_wdata = bus.req_wdata[int'(b_idx)*DW +: DW];

`ifdef RAM_ARB_HAZARD_EN
  assign hazard = a_found && b_found && (a_addr == b_addr) && (a_we || b_we);
`else
  assign hazard = 1'b0;
`endif

  assign b_gnt = b_found && !hazard;

  always_comb begin : grant
    gnt_v = '0;
    if (a_found) gnt_v[a_idx] = 1'b1;
    if (b_gnt)   gnt_v[b_idx] = 1'b1;
  end

  assign bus.gnt = gnt_v;

  // Idle ports are driven to zero so the RAM sees no stray writes.
  assign ram_wea   = a_found && a_we;
  assign ram_addra = a_found ? a_addr  : '0;
  assign ram_dina  = a_found ? a_wdata : '0;
  assign ram_web   = b_gnt && b_we;
  assign ram_addrb = b_gnt ? b_addr  : '0;
  assign ram_dinb  = b_gnt ? b_wdata : '0;

  always_comb begin : next_ptr
    ptr_nxt = ptr;
    if (b_gnt)
      ptr_nxt = (int'(b_idx) == N-1) ? '0 : b_idx + 1'b1;
    else if (a_found)
      ptr_nxt = (int'(a_idx) == N-1) ? '0 : a_idx + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      own_a_vld <= 1'b0;
      own_a_idx <= '0;
      own_b_vld <= 1'b0;
      own_b_idx <= '0;
      rdata_q   <= '0;
    end else begin
      ptr       <= ptr_nxt;
      own_a_vld <= a_found && !a_we;
      own_a_idx <= a_idx;
      own_b_vld <= b_gnt && !b_we;
      own_b_idx <= b_idx;
      rdata_q   <= rdata_v;
    end
  end

  // RAM read data arrives the cycle after the grant; the lane shows it live and keeps it afterwards.
  always_comb begin : read_return
    rvalid_v = '0;
    rdata_v  = rdata_q;
    if (own_a_vld) begin
      rvalid_v[own_a_idx]               = 1'b1;
      rdata_v[int'(own_a_idx)*DW +: DW] = ram_douta;
    end
    if (own_b_vld) begin
      rvalid_v[own_b_idx]               = 1'b1;
      rdata_v[int'(own_b_idx)*DW +: DW] = ram_doutb;
    end
  end

  assign bus.rvalid = rvalid_v;
  assign bus.rdata  = rdata_v;

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: behavioural RAM, per-cycle reference model and directed scenarios.
// Build with or without RAM_ARB_HAZARD_EN to match the RTL configuration under test.
module tb_dpram_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;
  logic ram_clr;

  logic          ram_wea, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb;
  logic [DW-1:0] ram_douta, ram_doutb;

  dpram_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  dpram_rr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta),
    .ram_web   (ram_web),
    .ram_addrb (ram_addrb),
    .ram_dinb  (ram_dinb),
    .ram_doutb (ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first dual-port RAM with registered outputs.
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 2**AW; i++) ram_mem[i] <= '0;
    end else begin
      if (ram_wea) ram_mem[ram_addra] <= ram_dina;
      if (ram_web) ram_mem[ram_addrb] <= ram_dinb;
    end
    ram_douta <= ram_mem[ram_addra];
    ram_doutb <= ram_mem[ram_addrb];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return bus.req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return bus.req_wdata[i*DW +: DW];
  endfunction

  // Reference model state: who is next in line, what the RAM should hold, what reads come back.
  int              m_ptr;
  logic [DW-1:0]   exp_mem [2**AW];
  logic [N-1:0]    exp_rv;
  logic [N*DW-1:0] exp_rd;
  bit              st_valid;
  int              st_ptr;
  int              st_rd_idx [$];
  logic [DW-1:0]   st_rd_dat [$];
  int              st_wr_adr [$];
  logic [DW-1:0]   st_wr_dat [$];

  // Compare process: derive this cycle's winners from the request list and check every output.
  initial begin
    forever begin
      int order [$];
      int wa;
      int wb;
      logic [N-1:0]  e_gnt;
      logic          e_wea, e_web;
      logic [AW-1:0] e_addra, e_addrb;
      logic [DW-1:0] e_dina, e_dinb;
      @(negedge clk);
      if (!rst) begin
        order.delete();
        for (int k = 0; k < N; k++)
          if (bus.req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        wa = (order.size() > 0) ? order[0] : -1;
        wb = (order.size() > 1) ? order[1] : -1;
`ifdef RAM_ARB_HAZARD_EN
        if (wb >= 0 && addr_of(wa) == addr_of(wb) && (bus.req_we[wa] || bus.req_we[wb]))
          wb = -1;
`endif
        e_gnt = '0;
        e_wea = 1'b0; e_addra = '0; e_dina = '0;
        e_web = 1'b0; e_addrb = '0; e_dinb = '0;
        if (wa >= 0) begin
          e_gnt[wa] = 1'b1;
          e_wea = bus.req_we[wa]; e_addra = addr_of(wa); e_dina = wdata_of(wa);
        end
        if (wb >= 0) begin
          e_gnt[wb] = 1'b1;
          e_web = bus.req_we[wb]; e_addrb = addr_of(wb); e_dinb = wdata_of(wb);
        end
        check("model gnt",       bus.gnt,    e_gnt);
        check("model ram_wea",   ram_wea,    e_wea);
        check("model ram_addra", ram_addra,  e_addra);
        check("model ram_dina",  ram_dina,   e_dina);
        check("model ram_web",   ram_web,    e_web);
        check("model ram_addrb", ram_addrb,  e_addrb);
        check("model ram_dinb",  ram_dinb,   e_dinb);
        check("model rvalid",    bus.rvalid, exp_rv);
        check("model rdata",     bus.rdata,  exp_rd);
        st_rd_idx.delete(); st_rd_dat.delete();
        st_wr_adr.delete(); st_wr_dat.delete();
        st_ptr = (wb >= 0) ? (wb + 1) % N : (wa >= 0) ? (wa + 1) % N : m_ptr;
        foreach (order[j]) begin
          if (order[j] == wa || order[j] == wb) begin
            if (bus.req_we[order[j]]) begin
              st_wr_adr.push_back(int'(addr_of(order[j])));
              st_wr_dat.push_back(wdata_of(order[j]));
            end else begin
              st_rd_idx.push_back(order[j]);
              st_rd_dat.push_back(exp_mem[addr_of(order[j])]);
            end
          end
        end
        st_valid = 1'b1;
      end
    end
  end

  // Model commit at each edge; reset discards anything in flight.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ptr    = 0;
        exp_rv   = '0;
        exp_rd   = '0;
        st_valid = 1'b0;
        if (ram_clr)
          for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
      end else begin
        exp_rv = '0;
        if (st_valid) begin
          m_ptr = st_ptr;
          foreach (st_rd_idx[j]) begin
            exp_rv[st_rd_idx[j]]            = 1'b1;
            exp_rd[st_rd_idx[j]*DW +: DW]   = st_rd_dat[j];
          end
          foreach (st_wr_adr[j]) exp_mem[st_wr_adr[j]] = st_wr_dat[j];
        end
        st_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]               = 1'b1;
    bus.req_we[i]            = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic clear_all();
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  logic [N-1:0] t3_gnt [4];
  int           rv_cnt [N];

  initial begin
    rst     = 1'b1;
    ram_clr = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    ram_clr = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle gnt",    bus.gnt,    4'b0000);
      check("idle rvalid", bus.rvalid, 4'b0000);
      check("idle wea",    ram_wea,    1'b0);
      check("idle web",    ram_web,    1'b0);
      tick();
    end

    // Write then read back through requester 0.
    set_req(0, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    check("wr gnt",   bus.gnt,   4'b0001);
    check("wr wea",   ram_wea,   1'b1);
    check("wr addra", ram_addra, 4'd3);
    check("wr dina",  ram_dina,  8'hA5);
    tick();
    set_req(0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    check("rd gnt", bus.gnt, 4'b0001);
    check("rd wea", ram_wea, 1'b0);
    tick();
    clear_all();
    @(negedge clk);
    check("rd rvalid", bus.rvalid,    4'b0001);
    check("rd rdata0", bus.rdata[7:0], 8'hA5);
    tick();

    // Bring the pointer back to 0 with a lone requester 3 grant, then let it drain.
    set_req(3, 1'b0, 4'd0, 8'h00);
    tick();
    clear_all();
    tick();

    // All four reading: pairs alternate and each requester gets two returns.
    t3_gnt[0] = 4'b0011; t3_gnt[1] = 4'b1100; t3_gnt[2] = 4'b0011; t3_gnt[3] = 4'b1100;
    for (int i = 0; i < N; i++) begin
      rv_cnt[i] = 0;
      set_req(i, 1'b0, 4'(i + 2), 8'h00);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr gnt", bus.gnt, t3_gnt[c]);
      for (int i = 0; i < N; i++) rv_cnt[i] += int'(bus.rvalid[i]);
      tick();
    end
    clear_all();
    @(negedge clk);
    for (int i = 0; i < N; i++) rv_cnt[i] += int'(bus.rvalid[i]);
    tick();
    for (int i = 0; i < N; i++) check("rr rvalid count", rv_cnt[i], 2);

    // Same-address write (r0) and read (r2).
    set_req(0, 1'b1, 4'd7, 8'h3C);
    set_req(2, 1'b0, 4'd7, 8'h00);
`ifdef RAM_ARB_HAZARD_EN
    @(negedge clk);
    check("hz cyc1 gnt", bus.gnt, 4'b0001);
    check("hz cyc1 web", ram_web, 1'b0);
    tick();
    clr_req(0);
    @(negedge clk);
    check("hz cyc2 gnt",   bus.gnt,   4'b0100);
    check("hz cyc2 addra", ram_addra, 4'd7);
    tick();
    clear_all();
    @(negedge clk);
    check("hz rvalid", bus.rvalid,      4'b0100);
    check("hz rdata2", bus.rdata[23:16], 8'h3C);
    tick();
`else
    @(negedge clk);
    check("nohz gnt",   bus.gnt,   4'b0101);
    check("nohz wea",   ram_wea,   1'b1);
    check("nohz addra", ram_addra, 4'd7);
    check("nohz web",   ram_web,   1'b0);
    check("nohz addrb", ram_addrb, 4'd7);
    tick();
    clear_all();
    @(negedge clk);
    check("nohz rvalid", bus.rvalid, 4'b0100);
    tick();
`endif

    // Read granted to r1, then reset before the edge that would launch it.
    set_req(1, 1'b0, 4'd7, 8'h00);
    @(negedge clk);
    check("rst gnt", bus.gnt, 4'b0010);
    #2;
    rst = 1'b1;
    clear_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst rvalid", bus.rvalid, 4'b0000);
    tick();
    set_req(1, 1'b0, 4'd5, 8'h00);
    set_req(3, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    check("post rst gnt",   bus.gnt,   4'b1010);
    check("post rst addra", ram_addra, 4'd5);
    check("post rst addrb", ram_addrb, 4'd3);
    tick();
    clear_all();
    tick();
    set_req(3, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    check("r3 only gnt",   bus.gnt,   4'b1000);
    check("r3 only addra", ram_addra, 4'd3);
    check("r3 only web",   ram_web,   1'b0);
    tick();
    clear_all();
    @(negedge clk);
    check("r3 only rvalid", bus.rvalid,       4'b1000);
    check("r3 only rdata3", bus.rdata[31:24], 8'hA5);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
